kamus_regfile: RTL and testbench

- Integer register file at the receiving end of the WB-RegFile interface: 32 x 32-bit, x0 hardwired to zero.
- Accepts one write per cycle from the writeback stage and serves two combinational read ports to decode, with a same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard: decode marks a destination at issue, writeback clears it. Decode uses the busy flags for RAW stall decisions.

---
 rtl/kamus_regfile.sv | 124 ++++++++++++
 tb/tb_kamus_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/kamus_regfile.sv
// Integer register file with a two-read/one-write datapath, write-to-read bypass and a
// per-register pending-write scoreboard used by decode for RAW stall decisions.
module kamus_regfile #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned SB_CNT_W = 2,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            regfile_wr_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            issue_valid_i,
    input  logic            issue_wr_en_i,
    input  logic [AW-1:0]   issue_rd_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            sb_overflow_o
);

    localparam logic [SB_CNT_W-1:0] CntMax = '1;

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_q  [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d  [NUM_REGS];
    logic                overflow_q;
    logic                overflow_d;

    logic wr_hit;
    logic inc;
    logic same_reg;

    assign wr_hit   = regfile_wr_en_i && (rd_addr_i != '0);
    assign inc      = issue_valid_i && issue_wr_en_i && (issue_rd_addr_i != '0);
    assign same_reg = wr_hit && inc && (rd_addr_i == issue_rd_addr_i);

    // Bypass is suppressed during reset so the read ports present zero while rst_i is high.
    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] arr_val,
        input logic            bypass_en
    );
        logic [XLEN-1:0] val;
        val = arr_val;
        if (addr == '0) begin
            val = '0;
        end else if (bypass_en && (rd_addr_i == addr)) begin
            val = wb_data_i;
        end
        return val;
    endfunction

    // A writeback hitting the register this cycle retires one pending write; floored at 0.
    function automatic logic busy_port(
        input logic [AW-1:0]       addr,
        input logic [SB_CNT_W-1:0] cnt
    );
        logic busy;
        busy = (cnt != '0);
        if (addr == '0) begin
            busy = 1'b0;
        end else if (wr_hit && (rd_addr_i == addr) && (cnt == SB_CNT_W'(1))) begin
            busy = 1'b0;
        end
        return busy;
    endfunction

    always_comb begin
        rs1_data_o = read_port(rs1_addr_i, regs_q[rs1_addr_i], wr_hit && !rst_i);
        rs2_data_o = read_port(rs2_addr_i, regs_q[rs2_addr_i], wr_hit && !rst_i);
        rs1_busy_o = busy_port(rs1_addr_i, cnt_q[rs1_addr_i]);
        rs2_busy_o = busy_port(rs2_addr_i, cnt_q[rs2_addr_i]);
    end

    assign sb_overflow_o = overflow_q;

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[rd_addr_i] = wb_data_i;
        end
        regs_d[0] = '0;
    end

    // Issue and writeback on the same register cancel, even at a saturated count.
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (inc && !same_reg) begin
            if (cnt_q[issue_rd_addr_i] == CntMax) begin
                overflow_d = 1'b1;
            end else begin
                cnt_d[issue_rd_addr_i] = cnt_q[issue_rd_addr_i] + 1'b1;
            end
        end
        if (wr_hit && !same_reg) begin
            if (cnt_q[rd_addr_i] != '0) begin
                cnt_d[rd_addr_i] = cnt_q[rd_addr_i] - 1'b1;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_kamus_regfile.sv
// Self-checking bench for kamus_regfile: directed scenarios followed by a randomized phase,
// all checked against an array-based reference model of the register file and scoreboard.
module tb_kamus_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        regfile_wr_en_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] wb_data_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        issue_valid_i;
    logic        issue_wr_en_i;
    logic [4:0]  issue_rd_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        sb_overflow_o;

    kamus_regfile dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .regfile_wr_en_i (regfile_wr_en_i),
        .rd_addr_i       (rd_addr_i),
        .wb_data_i       (wb_data_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs1_data_o      (rs1_data_o),
        .rs2_data_o      (rs2_data_o),
        .issue_valid_i   (issue_valid_i),
        .issue_wr_en_i   (issue_wr_en_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .rs1_busy_o      (rs1_busy_o),
        .rs2_busy_o      (rs2_busy_o),
        .sb_overflow_o   (sb_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural values and outstanding-write counts as plain integers.
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_cnt[i]  = 0;
        end
        m_ovf = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (regfile_wr_en_i && rd_addr_i == a) return wb_data_i;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        int pending;
        if (a == 5'd0) return 1'b0;
        pending = m_cnt[a];
        if (regfile_wr_en_i && rd_addr_i == a) pending = pending - 1;
        return pending > 0;
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then advance the model.
    task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic iv, input logic iwe, input logic [4:0] ird);
        bit inc;
        bit dec;
        @(negedge clk_i);
        regfile_wr_en_i = we;
        rd_addr_i       = rd;
        wb_data_i       = wd;
        rs1_addr_i      = r1;
        rs2_addr_i      = r2;
        issue_valid_i   = iv;
        issue_wr_en_i   = iwe;
        issue_rd_addr_i = ird;
        #1;
        check("rs1_data", rs1_data_o, m_read(r1));
        check("rs2_data", rs2_data_o, m_read(r2));
        check("rs1_busy", 32'(rs1_busy_o), 32'(m_busy(r1)));
        check("rs2_busy", 32'(rs2_busy_o), 32'(m_busy(r2)));
        check("overflow", 32'(sb_overflow_o), 32'(m_ovf));
        inc = iv && iwe && (ird != 5'd0);
        dec = we && (rd != 5'd0);
        if (dec) m_regs[rd] = wd;
        if (!(inc && dec && ird == rd)) begin
            if (inc) begin
                if (m_cnt[ird] == 3) m_ovf = 1'b1;
                else m_cnt[ird] = m_cnt[ird] + 1;
            end
            if (dec && m_cnt[rd] > 0) m_cnt[rd] = m_cnt[rd] - 1;
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 5'd0, 32'h0, r1, r2, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        rst_i           = 1'b1;
        regfile_wr_en_i = 1'b0;
        rd_addr_i       = '0;
        wb_data_i       = '0;
        rs1_addr_i      = '0;
        rs2_addr_i      = '0;
        issue_valid_i   = 1'b0;
        issue_wr_en_i   = 1'b0;
        issue_rd_addr_i = '0;
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state on every address
        for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));
        check("reset_ovf", 32'(sb_overflow_o), 32'h0);

        // Same-cycle bypass, then array read
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
        check("t2_bypass", rs1_data_o, 32'hDEADBEEF);
        idle(5'd5, 5'd0);
        check("t2_array", rs1_data_o, 32'hDEADBEEF);

        // x0 is hardwired and never tracked
        step(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        check("t3_x0_wr_cycle", rs1_data_o, 32'h0);
        idle(5'd0, 5'd0);
        check("t3_x0_next", rs2_data_o, 32'h0);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
        idle(5'd0, 5'd0);
        check("t3_x0_busy", 32'(rs1_busy_o), 32'h0);

        // Issue rd=7, resolve by writeback three cycles later
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd7);
        check("t4_c0_busy", 32'(rs2_busy_o), 32'h0);
        idle(5'd0, 5'd7);
        check("t4_c1_busy", 32'(rs2_busy_o), 32'h1);
        idle(5'd0, 5'd7);
        step(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0);
        check("t4_c3_busy", 32'(rs2_busy_o), 32'h0);
        check("t4_c3_data", rs2_data_o, 32'hA5A5A5A5);
        idle(5'd0, 5'd7);
        check("t4_c4_busy", 32'(rs2_busy_o), 32'h0);

        // Saturate rd=9 and overflow, then drain
        repeat (4) step(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 1'b1, 5'd9);
        idle(5'd9, 5'd0);
        check("t5_ovf_set", 32'(sb_overflow_o), 32'h1);
        step(1'b1, 5'd9, 32'h1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
        check("t5_wb1_busy", 32'(rs1_busy_o), 32'h1);
        step(1'b1, 5'd9, 32'h2, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
        check("t5_wb2_busy", 32'(rs1_busy_o), 32'h1);
        step(1'b1, 5'd9, 32'h3, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
        check("t5_wb3_busy", 32'(rs1_busy_o), 32'h0);
        idle(5'd9, 5'd0);
        check("t5_drained", 32'(rs1_busy_o), 32'h0);
        check("t5_ovf_sticky", 32'(sb_overflow_o), 32'h1);

        // Simultaneous issue and writeback on rd=4 leave the count at 1
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd4, 1'b1, 1'b1, 5'd4);
        step(1'b1, 5'd4, 32'h44, 5'd0, 5'd4, 1'b1, 1'b1, 5'd4);
        idle(5'd0, 5'd4);
        check("t6_still_busy", 32'(rs2_busy_o), 32'h1);

        // Asynchronous reset in the middle of a cycle
        @(negedge clk_i);
        rs1_addr_i = 5'd5;
        rs2_addr_i = 5'd4;
        #2;
        check("t6_pre_rst_data", rs1_data_o, 32'hDEADBEEF);
        rst_i = 1'b1;
        #1;
        check("t6_rst_data1", rs1_data_o, 32'h0);
        check("t6_rst_data2", rs2_data_o, 32'h0);
        check("t6_rst_busy", 32'(rs2_busy_o), 32'h0);
        check("t6_rst_ovf", 32'(sb_overflow_o), 32'h0);
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(5'd5, 5'd4);
        idle(5'd9, 5'd7);

        // Randomized traffic over a narrow address range to force hazards and collisions
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
